// File: rtl/lcd_line_fetcher.sv
// rtl/lcd_line_fetcher.sv - SDRAM line prefetcher with ping-pong line buffer feeding the LCDC
// Optional underrun pixel counter output when LCD_UNDERRUN_COUNT_EN is defined.
module lcd_line_fetcher #(
  parameter int HACT   = 480,
  parameter int VACT   = 272,
  parameter int BURST  = 16,
  parameter int STRIDE = 480,
  parameter int ADDR_W = 24
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_rd,
  input  logic [15:0]       i_x,
  input  logic              i_newline,
  input  logic              i_newframe,
  output logic [4:0]        o_red,
  output logic [5:0]        o_grn,
  output logic [4:0]        o_blu,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_mem_valid,
  input  logic [15:0]       i_mem_data,
  output logic              o_underrun
`ifdef LCD_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]       o_underrun_cnt
`endif
);

  localparam int NBURST = HACT / BURST;
  localparam int KW     = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int BW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int XW     = (HACT > 1) ? $clog2(HACT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;
  state_t state_q, state_d;

  logic [15:0]       f_q, d_q;
  logic [1:0]        full_q, full_d;
  logic              active_q;
  logic [ADDR_W-1:0] line_addr_q, addr_q;
  logic [KW-1:0]     k_q;
  logic [BW-1:0]     beat_q;
  logic              drain_q;
  logic              underrun_q;
  logic [15:0]       bank0_q [HACT];
  logic [15:0]       bank1_q [HACT];

  logic          beat_fire, burst_done, last_burst, line_done;
  logic          disp_adv, under_px, fetch_go;
  logic [XW-1:0] wr_idx, rd_idx;
  logic [15:0]   rd_word, pix;

  always_comb begin
    beat_fire  = (state_q == S_DATA) && i_mem_valid;
    burst_done = beat_fire && (beat_q == BW'(BURST - 1));
    last_burst = (k_q == KW'(NBURST - 1));
    // a burst finishing while draining or on a frame boundary never completes a line
    line_done  = burst_done && last_burst && !drain_q && !i_newframe;
    disp_adv   = i_newline && i_rd;
    under_px   = i_rd && !full_q[d_q[0]];
    fetch_go   = active_q && (f_q < 16'(VACT)) && !full_q[f_q[0]] && !i_newframe;
    wr_idx     = XW'(k_q) * XW'(BURST) + XW'(beat_q);
    rd_idx     = i_x[XW-1:0];
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fetch_go) state_d = S_REQ;
      S_REQ: begin
        if (i_mem_ack)       state_d = S_DATA;
        else if (i_newframe) state_d = S_IDLE;
      end
      S_DATA: begin
        if (burst_done)
          state_d = (last_burst || drain_q || i_newframe) ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req = (state_q == S_REQ);
  end

  always_comb begin
    full_d = full_q;
    if (disp_adv)   full_d[d_q[0]] = 1'b0;
    if (line_done)  full_d[f_q[0]] = 1'b1;
    if (i_newframe) full_d = 2'b00;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      f_q         <= '0;
      d_q         <= '0;
      full_q      <= '0;
      active_q    <= 1'b0;
      line_addr_q <= '0;
      addr_q      <= '0;
      k_q         <= '0;
      beat_q      <= '0;
      drain_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (beat_fire) beat_q <= burst_done ? '0 : beat_q + 1'b1;
      // an accepted burst cut by a frame boundary still returns BURST beats
      if (burst_done)
        drain_q <= 1'b0;
      else if (i_newframe && ((state_q == S_REQ && i_mem_ack) || state_q == S_DATA))
        drain_q <= 1'b1;
      if (state_q == S_IDLE && state_d == S_REQ)
        addr_q <= line_addr_q;
      else if (state_q == S_DATA && state_d == S_REQ)
        addr_q <= addr_q + ADDR_W'(BURST);
      if (i_newframe) begin
        active_q    <= i_enable;
        line_addr_q <= i_base;
        f_q         <= '0;
        d_q         <= '0;
        k_q         <= '0;
        underrun_q  <= 1'b0;
      end else begin
        if (line_done) begin
          f_q         <= f_q + 16'd1;
          line_addr_q <= line_addr_q + ADDR_W'(STRIDE);
        end
        if (burst_done && !drain_q) k_q <= last_burst ? '0 : k_q + 1'b1;
        if (disp_adv) d_q <= d_q + 16'd1;
        if (under_px) underrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (beat_fire && !drain_q && !i_newframe) begin
      if (f_q[0]) bank1_q[wr_idx] <= i_mem_data;
      else        bank0_q[wr_idx] <= i_mem_data;
    end
  end

  always_comb begin
    rd_word = d_q[0] ? bank1_q[rd_idx] : bank0_q[rd_idx];
    pix     = (i_rd && full_q[d_q[0]] && (i_x < 16'(HACT))) ? rd_word : 16'h0000;
    o_red   = pix[15:11];
    o_grn   = pix[10:5];
    o_blu   = pix[4:0];
  end

  assign o_mem_addr = addr_q;
  assign o_underrun = underrun_q;

`ifdef LCD_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)                                 ucnt_q <= '0;
    else if (i_newframe)                      ucnt_q <= '0;
    else if (under_px && ucnt_q != 16'hFFFF)  ucnt_q <= ucnt_q + 16'd1;
  end

  assign o_underrun_cnt = ucnt_q;
`endif

endmodule
